if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage, and a consumer of the pipeline controller's stall, flush and new_pc outputs.
- Holds the architectural fetch PC and issues single-outstanding fetch requests to instruction memory.
- Buffers one returned instruction when decode is stalled.
- Presents registered (pc, inst, valid) to ID.
- Redirect sources: exception flush from the controller and taken branches from ID.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall_i  in  7  controller stall vector; bit0 = hold PC/request issue, bit1 = hold IF output register.
- flush_i  in  1  controller flush; redirect to new_pc_i.
- new_pc_i  in  32  flush target.
- branch_flag_i  in  1  taken branch/jump from ID.
- branch_target_i  in  32  branch target.
- inst_req_o  out  1  fetch request valid.
- inst_addr_o  out  32  fetch address.
- inst_ready_i  in  1  memory accepts request.
- inst_valid_i  in  1  response valid.
- inst_data_i  in  32  response instruction.
- if_pc_o  out  32  PC of instruction to ID.
- if_inst_o  out  32  instruction to ID.
- if_valid_o  out  1  if_pc_o/if_inst_o valid.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high, and overrides everything.
- Values at reset:
  - pc_q = RESET_PC; state = IDLE; discard = 0; buffer empty.
  - inst_req_o = 0; if_valid_o = 0; if_pc_o = 0; if_inst_o = 0.
- Redirect priority: rst > flush_i > branch_flag_i > normal/stall.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request accepted, response pending.
  - HOLD: response captured in buffer while stall_i[1]=1.
- inst_req_o is combinational: = (state==IDLE) && !stall_i[0] && !flush_i && !branch_flag_i. inst_addr_o = pc_q.
- Request acceptance:
  - IDLE, inst_req_o && inst_ready_i -> WAIT; pc_q <= pc_q + PC_STEP; captured request PC held internally.
  - PC wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0).
  - Request low and inst_ready_i irrelevant when stall_i[0]=1.
- WAIT, on inst_valid_i:
  - discard=1: drop the response, clear discard -> IDLE.
  - Else stall_i[1]=0: next cycle if_pc_o = request PC, if_inst_o = inst_data_i, if_valid_o = 1 -> IDLE.
  - Else stall_i[1]=1: write buffer -> HOLD; outputs unchanged.
- HOLD: the first cycle with stall_i[1]=0 moves the buffer to the output register (if_valid_o=1) -> IDLE. No new request issues while in HOLD.
- Output register:
  - stall_i[1]=1: if_* holds its value.
  - stall_i[1]=0 with no new instruction: if_valid_o <= 0 (bubble); if_pc_o/if_inst_o retain their values.
- flush_i=1 (takes effect regardless of stall_i):
  - pc_q <= new_pc_i; if_valid_o <= 0; buffer dropped.
  - State: IDLE -> IDLE; HOLD -> IDLE.
  - WAIT without inst_valid_i: discard <= 1, stay in WAIT.
  - WAIT with inst_valid_i the same cycle: the response is dropped -> IDLE, discard stays 0.
  - The first request to new_pc_i issues the cycle after flush_i deasserts, if stall_i[0]=0.
- branch_flag_i=1 without flush_i:
  - Same kill actions as flush_i, with target branch_target_i.
  - if_valid_o <= 0 kills the wrong-path instruction currently at ID input; no delay slot.
- flush_i and branch_flag_i in the same cycle: flush wins, branch ignored.
- At most one request outstanding; inst_valid_i in IDLE/HOLD is a protocol violation and is ignored.
- Address alignment is not checked; pc_q[1:0] is passed through unchanged.

Test Plan:
- Reset then free-run, inst_ready_i=1, response 1 cycle after accept, data = address -> inst_addr_o 0,4,8; if_pc_o/if_inst_o 0→0, 4→4, ...; if_valid_o toggles 1/0 (2-cycle throughput); no request while in WAIT.
- stall_i=7'b0011111 asserted while WAIT, response arrives -> HOLD, if_* frozen, inst_req_o=0. Deassert stall -> next cycle if_valid_o=1 with the buffered pc/inst, then fetch resumes at pc+4.
- flush_i=1, new_pc_i=32'h0000000C while WAIT; response arrives 2 cycles later -> response dropped, if_valid_o=0, next request addr=0x0C, then if_pc_o=0x0C.
- flush_i and inst_valid_i in the same cycle with stall_i[1]=1 -> response dropped, discard=0, state IDLE, if_valid_o=0, next addr=new_pc_i.
- branch_flag_i=1, target 32'h00001000 while if_valid_o=1 (pc 0x8) -> if_valid_o=0 next cycle, next inst_addr_o=0x1000. Same-cycle flush_i + branch_flag_i -> next addr = new_pc_i.
- Boundaries:
  - RESET_PC=32'hFFFFFFFC -> second request addr = 0x0.
  - rst pulse while HOLD -> all outputs zero next cycle; request to RESET_PC follows.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage feeding the decode stage.
//
// Holds the architectural fetch PC, issues at most one outstanding request to
// instruction memory, buffers one returned instruction while decode is
// stalled, and presents a registered (pc, inst, valid) triple to ID.
// Redirects come from the pipeline controller (flush_i/new_pc_i, highest
// priority after reset) and from taken branches resolved in ID.
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset, overrides everything
//   stall_i[6:0]     controller stall vector; [0] holds PC / request issue,
//                    [1] holds the IF output register, upper bits unused here
//   flush_i          controller flush, redirect to new_pc_i
//   new_pc_i         flush target
//   branch_flag_i    taken branch/jump from ID
//   branch_target_i  branch target
//   inst_req_o       fetch request valid (combinational)
//   inst_addr_o      fetch address (always the current fetch PC)
//   inst_ready_i     memory accepts the request this cycle
//   inst_valid_i     response valid
//   inst_data_i      response instruction
//   if_pc_o          PC of the instruction presented to ID
//   if_inst_o        instruction presented to ID
//   if_valid_o       if_pc_o / if_inst_o are valid
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_data_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  // IDLE: nothing outstanding; WAIT: one request accepted, response pending;
  // HOLD: response parked in the buffer while ID is stalled.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // Sequential PC advance; 32-bit arithmetic wraps modulo 2^32 on its own.
  function automatic logic [31:0] pc_advance(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  state_e      state_r;
  state_e      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] req_pc_r;
  logic [31:0] req_pc_nxt_s;
  logic        discard_r;
  logic        discard_nxt_s;
  logic [31:0] buf_pc_r;
  logic [31:0] buf_inst_r;
  logic        buf_load_s;
  logic        out_load_s;
  logic [31:0] out_pc_s;
  logic [31:0] out_inst_s;
  logic [31:0] if_pc_r;
  logic [31:0] if_inst_r;
  logic        if_valid_r;
  logic        redirect_s;
  logic [31:0] redirect_pc_s;
  logic        inst_req_s;
  logic        accept_s;
  logic        unused_stall_s;

  // Upper stall bits belong to later stages.
  assign unused_stall_s = ^stall_i[6:2];

  // Resolve the redirect source: flush beats a same-cycle branch.
  always_comb begin
    if (flush_i) begin
      redirect_s    = 1'b1;
      redirect_pc_s = new_pc_i;
    end else if (branch_flag_i) begin
      redirect_s    = 1'b1;
      redirect_pc_s = branch_target_i;
    end else begin
      redirect_s    = 1'b0;
      redirect_pc_s = pc_r;
    end
  end

  // A request only goes out from IDLE, never during a redirect cycle (the new
  // target is fetched the cycle after) and never while reset is asserted.
  assign inst_req_s = !rst && (state_r == ST_IDLE) && !stall_i[0] && !redirect_s;
  assign accept_s   = inst_req_s && inst_ready_i;

  // Next-state, next-PC and output/buffer load decisions.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    req_pc_nxt_s  = req_pc_r;
    discard_nxt_s = discard_r;
    buf_load_s    = 1'b0;
    out_load_s    = 1'b0;
    out_pc_s      = req_pc_r;
    out_inst_s    = inst_data_i;
    case (state_r)
      ST_IDLE: begin
        if (redirect_s) begin
          pc_nxt_s = redirect_pc_s;
        end else if (accept_s) begin
          state_nxt_s  = ST_WAIT;
          pc_nxt_s     = pc_advance(pc_r);
          req_pc_nxt_s = pc_r;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (inst_valid_i) begin
          // The response always closes the outstanding request; it is
          // dropped if it belongs to a killed path (earlier or this cycle).
          state_nxt_s   = ST_IDLE;
          discard_nxt_s = 1'b0;
          if (redirect_s) begin
            pc_nxt_s = redirect_pc_s;
          end else begin
            pc_nxt_s = pc_r;
          end
          if (discard_r || redirect_s) begin
            buf_load_s = 1'b0;
            out_load_s = 1'b0;
          end else if (stall_i[1]) begin
            buf_load_s  = 1'b1;
            state_nxt_s = ST_HOLD;
          end else begin
            out_load_s = 1'b1;
            out_pc_s   = req_pc_r;
            out_inst_s = inst_data_i;
          end
        end else if (redirect_s) begin
          // Response still in flight: remember to throw it away on arrival.
          discard_nxt_s = 1'b1;
          pc_nxt_s      = redirect_pc_s;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_s) begin
          state_nxt_s = ST_IDLE;
          pc_nxt_s    = redirect_pc_s;
        end else if (!stall_i[1]) begin
          state_nxt_s = ST_IDLE;
          out_load_s  = 1'b1;
          out_pc_s    = buf_pc_r;
          out_inst_s  = buf_inst_r;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        discard_nxt_s = 1'b0;
      end
    endcase
  end

  // Fetch control state, PC and captured request PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pc_r      <= RESET_PC;
      req_pc_r  <= 32'h0000_0000;
      discard_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      req_pc_r  <= req_pc_nxt_s;
      discard_r <= discard_nxt_s;
    end
  end

  // One-entry skid buffer; occupancy is implied by the HOLD state.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_pc_r   <= 32'h0000_0000;
      buf_inst_r <= 32'h0000_0000;
    end else if (buf_load_s) begin
      buf_pc_r   <= req_pc_r;
      buf_inst_r <= inst_data_i;
    end else begin
      buf_pc_r   <= buf_pc_r;
      buf_inst_r <= buf_inst_r;
    end
  end

  // IF/ID output register: redirect kills, stall holds, otherwise bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc_r    <= 32'h0000_0000;
      if_inst_r  <= 32'h0000_0000;
      if_valid_r <= 1'b0;
    end else if (redirect_s) begin
      if_valid_r <= 1'b0;
    end else if (out_load_s) begin
      if_pc_r    <= out_pc_s;
      if_inst_r  <= out_inst_s;
      if_valid_r <= 1'b1;
    end else if (stall_i[1]) begin
      if_valid_r <= if_valid_r;
    end else begin
      if_valid_r <= 1'b0;
    end
  end

  assign inst_req_o  = inst_req_s;
  assign inst_addr_o = pc_r;
  assign if_pc_o     = if_pc_r;
  assign if_inst_o   = if_inst_r;
  assign if_valid_o  = if_valid_r;

endmodule
